// File: rtl/fpmul_sched.sv
// Two-requester round-robin scheduler wrapped around the shared combinational
// single-precision multiplier, with a response buffer that holds until accepted.

// Combinational single-precision multiplier. Mantissa is truncated, and
// zero/denormal operands give a signed zero. An all-ones exponent on either
// side raises exception and forces Result to zero.
module mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);
    logic        sign;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] ma;
    logic [47:0] mb;
    logic [47:0] prod;
    logic        norm;
    logic [22:0] mant;
    logic [9:0]  exp_biased;
    logic [9:0]  exp_unb;
    logic        unused_bits;

    always_comb begin
        sign = a[31] ^ b[31];
        ea   = a[30:23];
        eb   = b[30:23];
        ma   = {24'd0, 1'b1, a[22:0]};
        mb   = {24'd0, 1'b1, b[22:0]};
        prod = ma * mb;
        norm = prod[47];
        mant = norm ? prod[46:24] : prod[45:23];
        // The exponent sum keeps the +127 bias twice, so range checks use 127 and 382.
        exp_biased = {2'b00, ea} + {2'b00, eb} + {9'd0, norm};
        exp_unb    = exp_biased - 10'd127;

        exception = (&ea) | (&eb);
        overflow  = 1'b0;
        underflow = 1'b0;
        result    = {sign, exp_unb[7:0], mant};
        if (exception) begin
            result = 32'd0;
        end else if (ea == 8'd0 || eb == 8'd0) begin
            result = {sign, 31'd0};
        end else if (exp_biased >= 10'd382) begin
            overflow = 1'b1;
            result   = {sign, 8'hFF, 23'd0};
        end else if (exp_biased <= 10'd127) begin
            underflow = 1'b1;
            result    = {sign, 31'd0};
        end
    end

    assign unused_bits = ^{prod[22:0], exp_unb[9:8]};
endmodule

// Handshake: a transfer occurs on a rising edge where valid and ready are both
// high. reqN_ready is combinational from the valids and state; rsp_valid holds
// with stable payload until rsp_ready is seen.
module fpmul_sched #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_exception,
    output logic        rsp_overflow,
    output logic        rsp_underflow,
    output logic        busy,
    output logic [15:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state;
    logic        last_grant;
    logic        grant;
    logic        grant_valid;
    logic        id_q;
    logic [3:0]  cnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] mul_result;
    logic        mul_exception;
    logic        mul_overflow;
    logic        mul_underflow;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        if (req0_valid & req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) & grant_valid & ~grant;
    assign req1_ready = (state == IDLE) & grant_valid & grant;

    mul u_mul (
        .a         (op_a),
        .b         (op_b),
        .result    (mul_result),
        .exception (mul_exception),
        .overflow  (mul_overflow),
        .underflow (mul_underflow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            id_q          <= 1'b0;
            cnt           <= 4'd0;
            op_a          <= 32'd0;
            op_b          <= 32'd0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_result    <= 32'd0;
            rsp_exception <= 1'b0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            busy          <= 1'b0;
            op_count      <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        op_a       <= grant ? req1_a : req0_a;
                        op_b       <= grant ? req1_b : req0_b;
                        id_q       <= grant;
                        last_grant <= grant;
                        cnt        <= CNT_LOAD;
                        state      <= EXEC;
                        busy       <= 1'b1;
                    end
                end
                EXEC: begin
                    // Operands have driven mul for EXEC_CYCLES cycles once cnt hits 0.
                    if (cnt == 4'd0) begin
                        rsp_result    <= mul_result;
                        rsp_exception <= mul_exception;
                        rsp_overflow  <= mul_overflow;
                        rsp_underflow <= mul_underflow;
                        rsp_id        <= id_q;
                        rsp_valid     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpmul_sched.sv
// Bench for fpmul_sched: two instances (EXEC_CYCLES 1 and 3) behind one
// stimulus set, checked against an arithmetic multiplier and arbitration model.
module tb_fpmul_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;

    logic        req0_ready_e1, req1_ready_e1, rsp_valid_e1, rsp_id_e1, busy_e1;
    logic        rsp_exception_e1, rsp_overflow_e1, rsp_underflow_e1;
    logic [31:0] rsp_result_e1;
    logic [15:0] op_count_e1;
    logic        req0_ready_e3, req1_ready_e3, rsp_valid_e3, rsp_id_e3, busy_e3;
    logic        rsp_exception_e3, rsp_overflow_e3, rsp_underflow_e3;
    logic [31:0] rsp_result_e3;
    logic [15:0] op_count_e3;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
    logic        rsp_exception, rsp_overflow, rsp_underflow;
    logic [31:0] rsp_result;
    logic [15:0] op_count;

    int          checks = 0;
    int          errors = 0;
    int          exec_cycles;
    logic        model_last [2];
    logic [15:0] model_count [2];
    logic [32:0] exp_q [$];

    always #5 clk = ~clk;

    fpmul_sched #(.EXEC_CYCLES(1)) u_e1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid & ~sel), .req0_ready(req0_ready_e1), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid & ~sel), .req1_ready(req1_ready_e1), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid_e1), .rsp_ready(rsp_ready), .rsp_id(rsp_id_e1), .rsp_result(rsp_result_e1),
        .rsp_exception(rsp_exception_e1), .rsp_overflow(rsp_overflow_e1), .rsp_underflow(rsp_underflow_e1),
        .busy(busy_e1), .op_count(op_count_e1)
    );

    fpmul_sched #(.EXEC_CYCLES(3)) u_e3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid & sel), .req0_ready(req0_ready_e3), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid & sel), .req1_ready(req1_ready_e3), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid_e3), .rsp_ready(rsp_ready), .rsp_id(rsp_id_e3), .rsp_result(rsp_result_e3),
        .rsp_exception(rsp_exception_e3), .rsp_overflow(rsp_overflow_e3), .rsp_underflow(rsp_underflow_e3),
        .busy(busy_e3), .op_count(op_count_e3)
    );

    assign req0_ready    = sel ? req0_ready_e3    : req0_ready_e1;
    assign req1_ready    = sel ? req1_ready_e3    : req1_ready_e1;
    assign rsp_valid     = sel ? rsp_valid_e3     : rsp_valid_e1;
    assign rsp_id        = sel ? rsp_id_e3        : rsp_id_e1;
    assign rsp_result    = sel ? rsp_result_e3    : rsp_result_e1;
    assign rsp_exception = sel ? rsp_exception_e3 : rsp_exception_e1;
    assign rsp_overflow  = sel ? rsp_overflow_e3  : rsp_overflow_e1;
    assign rsp_underflow = sel ? rsp_underflow_e3 : rsp_underflow_e1;
    assign busy          = sel ? busy_e3          : busy_e1;
    assign op_count      = sel ? op_count_e3      : op_count_e1;

    // Reference multiply: {exception, overflow, underflow, result}.
    function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        longint p;
        logic   s;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) return {3'b100, 32'd0};
        if (ea == 0 || eb == 0) return {3'b000, s, 31'd0};
        p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
        e = ea + eb - 127;
        if (p >= (longint'(1) << 47)) begin
            e = e + 1;
            p = p >> 24;
        end else begin
            p = p >> 23;
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0) return {3'b001, s, 31'd0};
        return {3'b000, s, e[7:0], p[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        case ($urandom_range(0, 7))
            0:       e = 8'hFF;
            1:       e = 8'h00;
            2:       e = 8'($urandom_range(200, 254));
            3:       e = 8'($urandom_range(1, 50));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation with rsp_ready held high; mask selects which requesters are valid.
    task automatic run_op(input logic [1:0] mask, input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] a1, input logic [31:0] b1);
        logic        g;
        logic [34:0] r;
        int          n;
        g = (mask == 2'b11) ? ~model_last[sel] : mask[1];
        r = g ? ref_mul(a1, b1) : ref_mul(a0, b0);
        step();
        req0_valid = mask[0]; req0_a = a0; req0_b = b0;
        req1_valid = mask[1]; req1_a = a1; req1_b = b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        chk("grant0", {31'd0, req0_ready}, {31'd0, ~g});
        chk("grant1", {31'd0, req1_ready}, {31'd0, g});
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        model_last[sel] = g;
        @(negedge clk);
        chk("busy_exec", {31'd0, busy}, 32'd1);
        n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(exec_cycles + 1));
        chk("result", rsp_result, r[31:0]);
        chk("flags", {29'd0, rsp_exception, rsp_overflow, rsp_underflow}, {29'd0, r[34:32]});
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, g});
        model_count[sel] = model_count[sel] + 16'd1;
        step();
        @(negedge clk);
        chk("op_count", {16'd0, op_count}, {16'd0, model_count[sel]});
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("result_hold", rsp_result, r[31:0]);
    endtask

    // Arbitration properties that hold in every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert (!(req0_ready_e1 && req1_ready_e1) && !(req0_ready_e3 && req1_ready_e3)) else begin
                errors++;
                $error("FAIL ready_onehot observed %b%b/%b%b expected not both", req0_ready_e1,
                       req1_ready_e1, req0_ready_e3, req1_ready_e3);
            end
            checks++;
            assert (!((req0_ready_e1 || req1_ready_e1) && busy_e1) &&
                    !((req0_ready_e3 || req1_ready_e3) && busy_e3)) else begin
                errors++;
                $error("FAIL ready_when_busy observed busy %b/%b expected no ready", busy_e1, busy_e3);
            end
        end
    end

    initial begin
        logic        first, gexp;
        logic [32:0] e;
        logic [34:0] r;
        logic [31:0] held_result;
        logic [3:0]  held_misc;
        int          ng, nr, last_c, n;

        rst = 1'b1; sel = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
        model_last[0] = 1'b1; model_last[1] = 1'b1;
        model_count[0] = 16'd0; model_count[1] = 16'd0;
        exec_cycles = 1;

        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("rst_op_count", {16'd0, op_count}, 32'd0);
            chk("rst_result", rsp_result, 32'd0);
            chk("rst_misc", {28'd0, rsp_id, rsp_exception, rsp_overflow, rsp_underflow}, 32'd0);
        end
        sel = 1'b0;
        step();
        rst = 1'b0;

        // Directed single ops on the EXEC_CYCLES=1 instance.
        run_op(2'b01, 32'h40000000, 32'h40400000, 32'd0, 32'd0);
        chk("tp_mul_2x3", rsp_result, 32'h40C00000);
        chk("tp_op_count1", {16'd0, op_count}, 32'd1);
        run_op(2'b10, 32'd0, 32'd0, 32'h7F000000, 32'h7F000000);
        chk("tp_ovf_result", rsp_result, 32'h7F800000);
        chk("tp_ovf_flag", {31'd0, rsp_overflow}, 32'd1);
        run_op(2'b01, 32'h00800000, 32'h00800000, 32'd0, 32'd0);
        chk("tp_unf_result", rsp_result, 32'h00000000);
        chk("tp_unf_flag", {31'd0, rsp_underflow}, 32'd1);
        run_op(2'b10, 32'd0, 32'd0, 32'h7F800000, 32'h3F800000);
        chk("tp_exc_result", rsp_result, 32'h00000000);
        chk("tp_exc_flag", {31'd0, rsp_exception}, 32'd1);

        for (int i = 0; i < 16; i++) begin
            run_op(2'($urandom_range(1, 3)), rand_op(), rand_op(), rand_op(), rand_op());
        end

        // Both requesters held valid: grants and responses must alternate.
        step();
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'h40A00000;
        req1_valid = 1'b1; req1_a = 32'hC0200000; req1_b = 32'h3E800000;
        rsp_ready  = 1'b1;
        first = ~model_last[0];
        for (int i = 0; i < 4; i++) begin
            gexp = first ^ i[0];
            r = gexp ? ref_mul(req1_a, req1_b) : ref_mul(req0_a, req0_b);
            exp_q.push_back({gexp, r[31:0]});
        end
        ng = 0; nr = 0; last_c = 0;
        for (int c = 0; c < 60 && nr < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                gexp = first ^ ng[0];
                chk("alt_grant", {31'd0, req1_ready}, {31'd0, gexp});
                if (ng > 0) chk("alt_spacing", 32'(c - last_c), 32'(exec_cycles + 2));
                last_c = c;
                ng++;
            end
            if (rsp_valid) begin
                chk("alt_rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("alt_id", {31'd0, rsp_id}, {31'd0, e[32]});
                    chk("alt_result", rsp_result, e[31:0]);
                end
                nr++;
            end
            step();
            if (ng == 4) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("alt_grants", 32'(ng), 32'd4);
        chk("alt_rsps", 32'(nr), 32'd4);
        model_last[0] = ~first;
        model_count[0] = model_count[0] + 16'd4;
        @(negedge clk);
        chk("alt_op_count", {16'd0, op_count}, {16'd0, model_count[0]});

        // Backpressure on the EXEC_CYCLES=3 instance.
        sel = 1'b1;
        exec_cycles = 3;
        r = ref_mul(32'h3FC00000, 32'hC0A00000);
        step();
        req0_valid = 1'b1; req0_a = 32'h3FC00000; req0_b = 32'hC0A00000;
        rsp_ready  = 1'b0;
        @(negedge clk);
        chk("bp_accept", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 32'h41200000; req1_b = 32'h3DCCCCCD;
        model_last[1] = 1'b0;
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 40) begin
            chk("bp_pending_ready", {31'd0, req1_ready}, 32'd0);
            step();
            @(negedge clk);
            n++;
        end
        chk("bp_latency", 32'(n), 32'(exec_cycles + 1));
        chk("bp_result", rsp_result, r[31:0]);
        chk("bp_id", {31'd0, rsp_id}, 32'd0);
        held_result = rsp_result;
        held_misc   = {rsp_id, rsp_exception, rsp_overflow, rsp_underflow};
        for (int k = 1; k < 6; k++) begin
            step();
            @(negedge clk);
            chk("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", rsp_result, held_result);
            chk("bp_hold_misc", {28'd0, rsp_id, rsp_exception, rsp_overflow, rsp_underflow}, {28'd0, held_misc});
            chk("bp_hold_ready1", {31'd0, req1_ready}, 32'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_last_hold_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("bp_rsp_dropped", {31'd0, rsp_valid}, 32'd0);
        chk("bp_req1_accept", {31'd0, req1_ready}, 32'd1);
        chk("bp_op_count1", {16'd0, op_count}, 32'd1);
        r = ref_mul(req1_a, req1_b);
        step();
        req1_valid = 1'b0;
        model_last[1] = 1'b1;
        @(negedge clk);
        n = 1;
        while (!rsp_valid && n < 40) begin
            step();
            @(negedge clk);
            n++;
        end
        chk("bp2_latency", 32'(n), 32'(exec_cycles + 1));
        chk("bp2_id", {31'd0, rsp_id}, 32'd1);
        chk("bp2_result", rsp_result, r[31:0]);
        step();
        @(negedge clk);
        chk("bp_op_count2", {16'd0, op_count}, 32'd2);

        // Reset during EXEC discards the operation.
        step();
        req0_valid = 1'b1; req0_a = 32'h40400000; req0_b = 32'h40400000;
        @(negedge clk);
        chk("rm_accept", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rm_busy", {31'd0, busy}, 32'd0);
        chk("rm_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rm_op_count", {16'd0, op_count}, 32'd0);
        chk("rm_result", rsp_result, 32'd0);
        chk("rm_misc", {28'd0, rsp_id, rsp_exception, rsp_overflow, rsp_underflow}, 32'd0);
        chk("rm_op_count_e1", {16'd0, op_count_e1}, 32'd0);
        step();
        step();
        rst = 1'b0;
        model_last[0] = 1'b1; model_last[1] = 1'b1;
        model_count[0] = 16'd0; model_count[1] = 16'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rm_no_rsp", {31'd0, rsp_valid}, 32'd0);
            chk("rm_idle", {31'd0, busy}, 32'd0);
            step();
        end
        run_op(2'b11, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h40800000);
        chk("rm_first_id", {31'd0, rsp_id}, 32'd0);
        run_op(2'b11, 32'h3F800000, 32'h40000000, 32'h40800000, 32'h40800000);
        chk("rm_second_id", {31'd0, rsp_id}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpmul_sched.md
# fpmul_sched

Two-requester scheduler and result buffer for the team's combinational single-precision multiplier `mul`. It arbitrates round-robin between two operand sources and latches the granted operands into the multiplier. It holds those operands stable for a programmable settle time, then registers the result and flags into a response buffer. The response is held until the consumer accepts it. It sits between the ALU issue logic and the shared `mul` instance, which it instantiates internally.

## Interface
- EXEC_CYCLES, 1: cycles the latched operands drive `mul` before the result is sampled; legal range 1–15.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 operands accepted this cycle.
- req0_a, req0_b  in  32  requester 0 IEEE-754 single operands.
- req1_valid, req1_ready, req1_a, req1_b: the same for requester 1.
- rsp_valid  out  1  response buffer full.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that issued the buffered result.
- rsp_result  out  32  registered `mul` Result.
- rsp_exception, rsp_overflow, rsp_underflow  out  1  registered `mul` flags.
- busy  out  1  state is not IDLE.
- op_count  out  16  completed responses, counted on each rsp handshake; wraps 0xFFFF→0x0000.

## Operation
- States:
  - IDLE: may accept a request.
  - EXEC: operands are applied to `mul`.
  - RESP: the response is held.
- Reset values:
  - state = IDLE.
  - last_grant = 1, so requester 0 wins first.
  - Operand registers, rsp_* outputs, busy and op_count are all 0.
- IDLE, grant rule (combinational):
  - Only one valid: grant that requester.
  - Both valid: grant the requester ≠ last_grant.
- IDLE, accept: reqN_ready = (state==IDLE) & grant==N. At that edge:
  - latch a/b into the operand registers and N into the id register;
  - set last_grant = N;
  - load the cycle counter with EXEC_CYCLES-1;
  - go to EXEC.
- ready is never high outside IDLE. Both readies are never high in the same cycle.
- EXEC: the counter decrements each cycle. On the cycle the counter is 0:
  - capture `mul` Result, Exception, Overflow and Underflow into the rsp_* registers, and the id register into rsp_id;
  - set rsp_valid=1;
  - go to RESP.
- RESP, rsp_ready=1:
  - clear rsp_valid;
  - increment op_count;
  - go to IDLE.
  - rsp_result, rsp_id and the flags keep their last values after rsp_valid drops.
- RESP, rsp_ready=0: all rsp_* outputs hold stable, with no limit on how long.
- Requesters must hold valid, a and b stable until their ready is seen. Dropping valid before ready withdraws the request with no side effect.
- The block does not alter the `mul` output.
  - Result and flags are passed through bit-exact, including Result=0 on exception.
  - Special-case encoding of Inf, NaN, zero and denormal belongs to `mul`.
- Reset asserted mid-operation: in-flight operands and any buffered response are discarded, with no response emitted. All outputs return to reset values asynchronously.

## Timing
- A handshake at edge t gives EXEC during cycles t+1 … t+EXEC_CYCLES. Result is captured at the end of cycle t+EXEC_CYCLES. rsp_valid is high from cycle t+EXEC_CYCLES+1.
- Minimum spacing between accepts is EXEC_CYCLES+2 cycles. This minimum applies when rsp_ready is held high: RESP lasts 1 cycle and IDLE accepts on the next cycle.
- A request valid in IDLE is accepted in the same cycle, so ready is combinational from valid and state.
- busy is a registered function of state: high from t+1 until the cycle after the rsp handshake.
- A requester that is continuously valid waits at most one operation for the other requester. There is no starvation.

## Test plan
- Single op, EXEC_CYCLES=1: req0 sends a=0x40000000, b=0x40400000, rsp_ready high.
  - req0_ready is high in cycle 0.
  - rsp_valid is high in cycle 2 with rsp_result=0x40C00000, rsp_id=0, all flags 0.
  - op_count reads 1 after the handshake.
- Both requesters valid from reset and held valid:
  - grants alternate 0,1,0,1;
  - rsp_id sequence is 0,1,0,1;
  - each accept is separated by EXEC_CYCLES+2 cycles.
- Overflow: 0x7F000000 × 0x7F000000 → rsp_result=0x7F800000, rsp_overflow=1. Underflow: 0x00800000 × 0x00800000 → rsp_result=0x00000000, rsp_underflow=1.
- Exception: 0x7F800000 × 0x3F800000 → rsp_exception=1, rsp_result=0x00000000.
- Backpressure, EXEC_CYCLES=3: hold rsp_ready low for 6 cycles after rsp_valid rises.
  - rsp_* are stable throughout.
  - A pending req1_valid sees ready=0 throughout.
  - req1 is accepted the cycle after the rsp handshake.
- Reset mid-operation: assert rst during EXEC.
  - Outputs go to 0 immediately and no response appears.
  - After release, the first simultaneous requests grant requester 0.
  - op_count restarts from 0.
